// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Brief    : Shared widths, tag-field layout and FSM encoding for the
//            2-way / 16-set write-back data-cache controller.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int TAG_W       = 23;
    localparam int INDEX_W     = 4;
    localparam int LINE_W      = 256;
    localparam int WORD_W      = 32;
    localparam int OFFSET_W    = 3;
    localparam int TAG_FIELD_W = TAG_W + 2;

    // Layout of the 25-bit SRAM tag field: {valid, dirty, tag}
    localparam int VALID_BIT   = 24;
    localparam int DIRTY_BIT   = 23;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2,
        ST_INSTALL   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_word_merge.sv
`default_nettype none
// ============================================================================
// Module   : dcache_word_merge
// Brief    : Selects one 32-bit word from a cache line and produces the same
//            line with that word replaced by store data.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0]   i_line,
    input  logic [OFFSET_W-1:0] i_offset,
    input  logic [WORD_W-1:0]   i_wdata,
    output logic [WORD_W-1:0]   o_rdata,
    output logic [LINE_W-1:0]   o_line
);

    localparam int c_num_words = LINE_W / WORD_W;

    genvar gi;
    generate
        for (gi = 0; gi < c_num_words; gi++) begin : g_word
            assign o_line[gi*WORD_W +: WORD_W] =
                (i_offset == OFFSET_W'(gi)) ? i_wdata : i_line[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign o_rdata = i_line[i_offset*WORD_W +: WORD_W];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : Write-back data-cache controller. Serves hits combinationally,
//            stalls on misses, writes back dirty victims, refills from memory
//            and installs the refilled line through the SRAM write port.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    // CPU MEM stage
    input  logic                   cpu_req_i,
    input  logic                   cpu_write_i,
    input  logic [31:0]            cpu_addr_i,
    input  logic [31:0]            cpu_data_i,
    output logic [31:0]            cpu_data_o,
    output logic                   cpu_stall_o,
    // data memory
    output logic                   mem_enable_o,
    output logic                   mem_write_o,
    output logic [31:0]            mem_addr_o,
    output logic [LINE_W-1:0]      mem_data_o,
    input  logic [LINE_W-1:0]      mem_data_i,
    input  logic                   mem_ack_i,
    // cache SRAM
    output logic [INDEX_W-1:0]     sram_addr_o,
    output logic [TAG_FIELD_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0]      sram_data_o,
    output logic                   sram_enable_o,
    output logic                   sram_write_o,
    input  logic [TAG_FIELD_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]      sram_data_i,
    input  logic                   sram_hit_i
);

    state_t              r_state;
    state_t              w_state_next;

    logic                r_mem_enable;
    logic                r_mem_write;
    logic [31:0]         r_mem_addr;
    logic [LINE_W-1:0]   r_mem_data;
    logic [LINE_W-1:0]   r_refill_line;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_index;
    logic [OFFSET_W-1:0] w_offset;
    logic                w_lookup;
    logic                w_hit;
    logic                w_miss;
    logic                w_victim_dirty;
    logic [WORD_W-1:0]   w_hit_word;
    logic [LINE_W-1:0]   w_merged_line;
    logic                w_unused;

    assign w_tag    = cpu_addr_i[31:9];
    assign w_index  = cpu_addr_i[8:5];
    assign w_offset = cpu_addr_i[4:2];
    assign w_unused = &{1'b0, cpu_addr_i[1:0]};

    // Lookups only happen in IDLE; other states are busy with the miss.
    assign w_lookup       = cpu_req_i & (r_state == ST_IDLE);
    assign w_hit          = w_lookup & sram_hit_i;
    assign w_miss         = w_lookup & ~sram_hit_i;
    assign w_victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];

    dcache_word_merge u_word_merge (
        .i_line   (sram_data_i),
        .i_offset (w_offset),
        .i_wdata  (cpu_data_i),
        .o_rdata  (w_hit_word),
        .o_line   (w_merged_line)
    );

    // State register; reset abandons any outstanding miss.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; acks outside WRITEBACK/REFILL are ignored.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_miss) begin
                    w_state_next = w_victim_dirty ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                if (mem_ack_i) begin
                    w_state_next = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (mem_ack_i) begin
                    w_state_next = ST_INSTALL;
                end
            end
            ST_INSTALL: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Memory request registers: one-cycle enable pulse, address/data held until ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem_enable  <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data    <= '0;
            r_refill_line <= '0;
        end else begin
            r_mem_enable <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_miss) begin
                        r_mem_enable <= 1'b1;
                        r_mem_write  <= w_victim_dirty;
                        r_mem_addr   <= w_victim_dirty ? {sram_tag_i[TAG_W-1:0], w_index, 5'b0}
                                                       : {w_tag, w_index, 5'b0};
                        r_mem_data   <= sram_data_i;
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ack_i) begin
                        r_mem_enable <= 1'b1;
                        r_mem_write  <= 1'b0;
                        r_mem_addr   <= {w_tag, w_index, 5'b0};
                    end
                end
                ST_REFILL: begin
                    if (mem_ack_i) begin
                        r_refill_line <= mem_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // SRAM write port and CPU read data: store-hit merge in IDLE, refill in INSTALL.
    always_comb begin
        sram_write_o = 1'b0;
        sram_data_o  = w_merged_line;
        sram_tag_o   = {1'b1, cpu_write_i, w_tag};
        cpu_data_o   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    sram_write_o = cpu_write_i;
                    cpu_data_o   = w_hit_word;
                end
            end
            ST_INSTALL: begin
                sram_write_o = 1'b1;
                sram_data_o  = r_refill_line;
                sram_tag_o   = {1'b1, 1'b0, w_tag};
            end
            default: begin
            end
        endcase
    end

    assign sram_addr_o   = w_index;
    assign sram_enable_o = cpu_req_i | (r_state == ST_INSTALL);
    assign cpu_stall_o   = (r_state != ST_IDLE) | w_miss;

    assign mem_enable_o  = r_mem_enable;
    assign mem_write_o   = r_mem_write;
    assign mem_addr_o    = r_mem_addr;
    assign mem_data_o    = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Self-checking bench for dcache_ctrl with a 2-way LRU SRAM model,
//            a latency-randomised line memory and a word-level golden memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    logic         clk_i;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;

    dcache_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cpu_req_i     (cpu_req_i),
        .cpu_write_i   (cpu_write_i),
        .cpu_addr_i    (cpu_addr_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_data_o    (cpu_data_o),
        .cpu_stall_o   (cpu_stall_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .sram_addr_o   (sram_addr_o),
        .sram_tag_o    (sram_tag_o),
        .sram_data_o   (sram_data_o),
        .sram_enable_o (sram_enable_o),
        .sram_write_o  (sram_write_o),
        .sram_tag_i    (sram_tag_i),
        .sram_data_i   (sram_data_i),
        .sram_hit_i    (sram_hit_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- SRAM model: 2 ways x 16 sets, LRU victim ----------------
    logic         s_valid [16][2];
    logic         s_dirty [16][2];
    logic [22:0]  s_tag   [16][2];
    logic [255:0] s_data  [16][2];
    logic         s_lru   [16];
    bit           s_init_done = 0;

    function automatic int find_way(input logic [3:0] idx, input logic [22:0] tg);
        for (int w = 0; w < 2; w++) begin
            if (s_valid[idx][w] && s_tag[idx][w] == tg) return w;
        end
        return -1;
    endfunction

    function automatic int victim_way(input logic [3:0] idx);
        if (!s_valid[idx][0]) return 0;
        if (!s_valid[idx][1]) return 1;
        return s_lru[idx] ? 1 : 0;
    endfunction

    always_comb begin
        int hw;
        int vw;
        sram_hit_i  = 1'b0;
        sram_tag_i  = '0;
        sram_data_i = '0;
        hw = find_way(sram_addr_o, sram_tag_o[22:0]);
        vw = victim_way(sram_addr_o);
        if (hw >= 0) begin
            sram_hit_i  = 1'b1;
            sram_tag_i  = {s_valid[sram_addr_o][hw], s_dirty[sram_addr_o][hw], s_tag[sram_addr_o][hw]};
            sram_data_i = s_data[sram_addr_o][hw];
        end else begin
            sram_tag_i  = {s_valid[sram_addr_o][vw], s_dirty[sram_addr_o][vw], s_tag[sram_addr_o][vw]};
            sram_data_i = s_data[sram_addr_o][vw];
        end
    end

    // SRAM operation captured mid-cycle, applied at the next rising edge
    bit           op_en;
    bit           op_wr;
    logic [3:0]   op_idx;
    int           op_way;
    logic [24:0]  op_tag;
    logic [255:0] op_data;

    always @(negedge clk_i) begin
        int hw;
        op_en = 0;
        op_wr = 0;
        if (sram_enable_o) begin
            hw = find_way(sram_addr_o, sram_tag_o[22:0]);
            op_idx  = sram_addr_o;
            op_tag  = sram_tag_o;
            op_data = sram_data_o;
            if (sram_write_o) begin
                op_en  = 1;
                op_wr  = 1;
                op_way = (hw >= 0) ? hw : victim_way(sram_addr_o);
            end else if (hw >= 0) begin
                op_en  = 1;
                op_way = hw;
            end
        end
    end

    always @(posedge clk_i) begin
        if (!s_init_done) begin
            for (int i = 0; i < 16; i++) begin
                s_lru[i] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    s_valid[i][w] <= 1'b0;
                    s_dirty[i][w] <= 1'b0;
                    s_tag[i][w]   <= '0;
                    s_data[i][w]  <= '0;
                end
            end
            s_init_done <= 1;
        end else if (op_en) begin
            if (op_wr) begin
                s_valid[op_idx][op_way] <= op_tag[24];
                s_dirty[op_idx][op_way] <= op_tag[23];
                s_tag[op_idx][op_way]   <= op_tag[22:0];
                s_data[op_idx][op_way]  <= op_data;
            end
            s_lru[op_idx] <= (op_way == 0);
        end
    end

    // ---------------- memory + golden CPU-visible memory ----------------
    logic [255:0] mem  [logic [31:0]];
    logic [31:0]  gold [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem.exists(la)) return mem[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i*4));
        return l;
    endfunction

    function automatic logic [31:0] gold_word(input logic [31:0] a);
        if (gold.exists(a)) return gold[a];
        return init_word(a);
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold_word(la + 32'(i*4));
        return l;
    endfunction

    typedef struct {
        bit           w;
        logic [31:0]  a;
        logic [255:0] d;
    } tx_t;

    tx_t          txq[$];
    bit           pend;
    bit           pw;
    logic [31:0]  pa;
    logic [255:0] pd;
    int           cnt;
    int           lat_sum;
    int           force_lat;
    bit           auto_ack;
    logic [24:0]  last_install_tag;

    // One cycle of environment: memory responder and per-cycle protocol checks.
    task automatic tick();
        @(negedge clk_i);
        if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            if (pend && pw) mem[pa] = pd;
            pend = 0;
        end
        if (rst_i) begin
            pend = 0;
        end else begin
            if (mem_enable_o) begin
                check("mem_en_single_pulse", pend, 0);
                pend = 1;
                pw   = mem_write_o;
                pa   = mem_addr_o;
                pd   = mem_data_o;
                txq.push_back('{pw, pa, pd});
                cnt  = (force_lat != 0) ? force_lat : int'($urandom_range(1, 6));
                lat_sum += cnt;
            end else if (pend) begin
                check("mem_addr_held", mem_addr_o, pa);
                check("mem_write_held", mem_write_o, pw);
                if (pw) check("mem_data_held", mem_data_o, pd);
            end
            if (pend) check("stall_during_mem", cpu_stall_o, 1);
            if (sram_write_o && cpu_stall_o) last_install_tag = sram_tag_o;
            if (pend && auto_ack && cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_ack_i  = 1'b1;
                    mem_data_i = pw ? '0 : mem_line(pa);
                end
            end
        end
    endtask

    // One CPU access from request to commit, checked against the models.
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int nstall);
        logic [3:0]   idx;
        int           hw;
        int           vw;
        int           cyc;
        bit           done;
        bit           exp_wb;
        logic [31:0]  vaddr;
        logic [255:0] vline;
        int           ntx;
        idx    = a[8:5];
        hw     = find_way(idx, a[31:9]);
        exp_wb = 0;
        vaddr  = '0;
        vline  = '0;
        if (hw < 0) begin
            vw     = victim_way(idx);
            exp_wb = s_valid[idx][vw] && s_dirty[idx][vw];
            vaddr  = {s_tag[idx][vw], idx, 5'b0};
            if (exp_wb) vline = gold_line(vaddr);
        end
        txq.delete();
        lat_sum     = 0;
        cpu_req_i   = 1'b1;
        cpu_write_i = w;
        cpu_addr_i  = a;
        cpu_data_i  = d;
        nstall = 0;
        cyc    = 0;
        done   = 0;
        while (!done && cyc < 300) begin
            tick();
            cyc++;
            if (cpu_stall_o) nstall++;
            else done = 1;
        end
        check("access_completes", done, 1);
        rd  = cpu_data_o;
        ntx = txq.size();
        if (hw >= 0) begin
            check("hit_zero_stall", nstall, 0);
            check("hit_no_mem_tx", ntx, 0);
        end else begin
            check("miss_stall_cycles", nstall, 2 + lat_sum);
            check("miss_tx_count", ntx, exp_wb ? 2 : 1);
            if (exp_wb && ntx == 2) begin
                check("wb_is_write", txq[0].w, 1);
                check("wb_addr", txq[0].a, vaddr);
                check("wb_data", txq[0].d, vline);
            end
            if (ntx == (exp_wb ? 2 : 1)) begin
                check("refill_is_read", txq[ntx-1].w, 0);
                check("refill_addr", txq[ntx-1].a, {a[31:5], 5'b0});
            end
        end
        if (!w) check("load_data", cpu_data_o, gold_word(a));
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        if (w) begin
            gold[a] = d;
            hw = find_way(idx, a[31:9]);
            check("store_line_present", hw >= 0, 1);
            if (hw >= 0) begin
                check("store_word", s_data[idx][hw][a[4:2]*32 +: 32], d);
                check("store_dirty", s_dirty[idx][hw], 1);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            check("idle_no_stall", cpu_stall_o, 0);
            @(posedge clk_i);
            #1;
        end
    endtask

    function automatic tx_t tx_at(input int i);
        tx_t t;
        t = '{1'b0, 32'hFFFF_FFFF, '0};
        if (i < txq.size()) t = txq[i];
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          ns;
        int          wi;
        bit          seen;
        logic [31:0] a;

        rst_i = 1'b1;
        cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
        mem_ack_i = 1'b0; mem_data_i = '0;
        pend = 0; pw = 0; pa = '0; pd = '0; cnt = 0; lat_sum = 0;
        force_lat = 0; auto_ack = 1;
        last_install_tag = '1;

        // reset state
        repeat (3) @(posedge clk_i);
        #1;
        tick();
        check("rst_stall", cpu_stall_o, 0);
        check("rst_mem_enable", mem_enable_o, 0);
        check("rst_mem_write", mem_write_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_data", mem_data_o, 0);
        check("rst_cpu_data", cpu_data_o, 0);
        check("rst_sram_write", sram_write_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(2);

        // cold load -> clean miss
        force_lat = 3;
        access(0, 32'h0000_0040, 0, rd, ns);
        check("cold_load_word0", rd, 32'hA5A5_0040);
        check("cold_refill_addr", tx_at(0).a, 32'h0000_0040);
        check("cold_install_tag", last_install_tag, 25'h100_0000);
        check("cold_stall_literal", ns, 5);

        // store hit
        access(1, 32'h0000_0044, 32'hDEAD_BEEF, rd, ns);
        check("store_hit_stall_literal", ns, 0);
        wi = find_way(4'd2, 23'd0);
        check("store_hit_way_found", wi >= 0, 1);
        if (wi >= 0) begin
            check("store_hit_word1", s_data[2][wi][63:32], 32'hDEAD_BEEF);
            check("store_hit_dirty", s_dirty[2][wi], 1);
        end

        // second tag, ack after 10 cycles
        force_lat = 10;
        access(0, 32'h0000_0240, 0, rd, ns);
        check("lat10_stall_literal", ns, 12);

        // third tag evicts dirty 0x40 line
        force_lat = 0;
        access(0, 32'h0000_0440, 0, rd, ns);
        check("evict_wb_addr_literal", tx_at(0).a, 32'h0000_0040);
        check("evict_wb_write_literal", tx_at(0).w, 1);
        check("evict_wb_word1_literal", tx_at(0).d[63:32], 32'hDEAD_BEEF);
        check("evict_refill_addr_literal", tx_at(1).a, 32'h0000_0440);
        idle(1);

        // hit on 0x60 with a spurious ack in IDLE
        access(0, 32'h0000_0060, 0, rd, ns);
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_0060;
        tick();
        check("spur_hit_stall", cpu_stall_o, 0);
        check("spur_hit_data", cpu_data_o, gold_word(32'h0000_0060));
        mem_ack_i = 1'b1;
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;
        tick();
        check("spur_after_stall", cpu_stall_o, 0);
        check("spur_after_mem_en", mem_enable_o, 0);
        @(posedge clk_i);
        #1;
        access(0, 32'h0000_0064, 0, rd, ns);
        check("spur_followup_hit_stall", ns, 0);

        // reset asserted during REFILL
        auto_ack = 0;
        cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_0860;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (mem_enable_o) seen = 1;
        end
        check("rst_test_refill_started", seen, 1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        cpu_req_i = 1'b0;
        tick();
        check("midrst_stall", cpu_stall_o, 0);
        check("midrst_mem_enable", mem_enable_o, 0);
        check("midrst_mem_write", mem_write_o, 0);
        check("midrst_mem_addr", mem_addr_o, 0);
        check("midrst_mem_data", mem_data_o, 0);
        check("midrst_sram_write", sram_write_o, 0);
        check("midrst_cpu_data", cpu_data_o, 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        tick();
        mem_ack_i  = 1'b1;
        mem_data_i = {8{32'h1234_5678}};
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            tick();
            check("late_ack_no_sram_write", sram_write_o, 0);
            check("late_ack_no_mem_en", mem_enable_o, 0);
            check("late_ack_no_stall", cpu_stall_o, 0);
        end
        check("late_ack_not_installed", find_way(4'd3, 23'd4) >= 0, 0);
        @(posedge clk_i);
        #1;
        auto_ack = 1;
        access(0, 32'h0000_0860, 0, rd, ns);

        // randomized traffic: 4 tags x 4 sets to force conflicts and evictions
        for (int i = 0; i < 300; i++) begin
            a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5)
              | (32'($urandom_range(0, 7)) << 2);
            access(1'($urandom_range(0, 1)), a, $urandom, rd, ns);
            idle(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_ctrl.md
# dcache_ctrl

Controller for the 2-way, 16-set write-back data-cache SRAM, sitting between the CPU MEM stage and the 256-bit data memory. It decodes 32-bit CPU load/store addresses, serves hits combinationally, and stalls the pipeline on misses. On a miss it writes back a dirty victim line, refills the line from memory and installs it through the SRAM's write port. Replacement (LRU) is owned by the SRAM; the controller only presents tag and data.

## Interface
- TAG_W, 23, address tag width (addr[31:9])
- INDEX_W, 4, set index width (addr[8:5])
- LINE_W, 256, cache line width (32 bytes, 8 words)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- cpu_req_i  in  1  MEM-stage access valid
- cpu_write_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address, word-aligned
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data, valid when cpu_req_i & ~cpu_stall_o
- cpu_stall_o  out  1  freeze pipeline
- mem_enable_o  out  1  memory request pulse
- mem_write_o  out  1  1 = line write-back, 0 = line read
- mem_addr_o  out  32  line address, bits [4:0] = 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  single-cycle completion pulse
- sram_addr_o  out  4  set index
- sram_tag_o  out  25  {valid, dirty, tag[22:0]}
- sram_data_o  out  256  line to write
- sram_enable_o  out  1  SRAM access
- sram_write_o  out  1  SRAM write strobe
- sram_tag_i  in  25  hit-way tag, else victim-way tag
- sram_data_i  in  256  hit-way line, else victim line
- sram_hit_i  in  1  valid tag match in either way

## Operation
- Address split: tag = addr[31:9], index = addr[8:5], word = addr[4:2].
- sram_addr_o = index; sram_enable_o = cpu_req_i; sram_tag_o in lookup = {1, cpu_write_i, tag}.
- Load hit: cpu_data_o = sram_data_i[word*32 +: 32]; no SRAM write; stall 0.
- Store hit: sram_write_o = 1 for one cycle, sram_data_o = sram_data_i with word replaced by cpu_data_i, sram_tag_o = {1,1,tag}.
- Miss (cpu_req_i & ~sram_hit_i in IDLE): cpu_stall_o = 1 combinationally; next state WRITEBACK if sram_tag_i[24] & sram_tag_i[23], else REFILL.
- FSM states: IDLE, WRITEBACK, REFILL, INSTALL.
  - WRITEBACK: first cycle mem_enable_o = 1, mem_write_o = 1, mem_addr_o = {sram_tag_i[22:0], index, 5'b0}, mem_data_o = sram_data_i; victim line and address latched on entry. Wait mem_ack_i -> REFILL.
  - REFILL: first cycle mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, index, 5'b0}. Wait mem_ack_i; latch mem_data_i -> INSTALL.
  - INSTALL: sram_write_o = 1, sram_data_o = refill line, sram_tag_o = {1,0,tag} -> IDLE.
- Back in IDLE the access re-looks up, hits and completes by the hit rules (a store sets dirty then).
- cpu_stall_o = 1 in every non-IDLE state and on an IDLE miss.

## Timing
- Reset: state IDLE; mem_enable_o, mem_write_o, sram_write_o, cpu_stall_o = 0; mem_addr_o, mem_data_o, cpu_data_o = 0.
- Hit latency 0: data/stall resolved same cycle; store commits on that rising edge.
- Clean miss: stall = 1 for cycles: miss cycle + memory latency + 1 INSTALL; completes in the following IDLE cycle.
- Dirty miss: adds the write-back round trip before REFILL.
- mem_enable_o is a one-cycle pulse per request; mem_addr_o/mem_data_o are held stable until mem_ack_i.
- mem_ack_i in IDLE or INSTALL is ignored.
- cpu_req_i, cpu_addr_i, cpu_write_i and cpu_data_i are held stable by the pipeline while stalled; the controller does not re-sample them.
- rst_i mid-miss: immediate return to IDLE, outstanding memory transaction abandoned, SRAM not written.

## Structure
- Shared package dcache_pkg: TAG_W, INDEX_W, LINE_W, the tag-field bit positions (VALID_BIT = 24, DIRTY_BIT = 23), and the FSM state encoding.
- One sub-module: dcache_word_merge, combinational word select/replace on a 256-bit line by 3-bit offset.

## Test plan
- Cold load 0x0000_0040 -> clean miss, REFILL at 0x40, INSTALL with tag {1,0,0}, then load returns word 0 of the refill line.
- Store 0xDEADBEEF to 0x0000_0044 after the above -> hit, zero stall, line word 1 = 0xDEADBEEF, tag dirty = 1.
- Loads to 0x0000_0240, then 0x0000_0440 (same set 2, third tag) -> dirty 0x40 line evicted, WRITEBACK at 0x40 carrying 0xDEADBEEF before REFILL at 0x440.
- Memory ack after 10 cycles -> mem_enable_o high exactly one cycle, addresses held, stall continuous throughout.
- rst_i asserted in REFILL -> all outputs 0 next cycle, late mem_ack_i ignored, no SRAM write.
- Load hit on 0x0000_0060 with a spurious mem_ack_i in IDLE -> state stays IDLE, no stall.
